// File: rtl/tc_cheap_ram_requester.sv
// tc_cheap_ram_requester
//   Issues single load/save requests from a core to one latency RAM instance.
//   One request is in flight at a time. The four read words (or an error) are
//   returned on a response channel that stays valid until the core accepts it.
//
// Parameters
//   BIT_WIDTH       width of each data word
//   TIMEOUT_CYCLES  cycles spent waiting for mem_ready before a load errors out (2..255)
//   RAM_DEPTH       words in the attached RAM, used only by the optional range check
//
// Optional feature
//   TC_RAM_REQ_RANGE_CHECK_EN  when defined, a request whose addr+3 falls beyond
//                              RAM_DEPTH-1 is answered with an error and never reaches the RAM.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake; ready is high only while idle
//   req_write_i               1 = save, 0 = load
//   req_addr_i                base word address
//   req_wdata0..3_i           save data for addr+0..+3
//   resp_valid_o/resp_ready_i response handshake; valid held until accepted
//   resp_err_o                timeout or range error
//   resp_rdata0..3_o          load data; zero for saves and errors
//   mem_load_o/mem_save_o     RAM command strobes, one cycle each
//   mem_address_o             RAM base address, held between commands
//   mem_in0..3_o              RAM save data, zero outside a save
//   mem_ready_i               RAM load-complete pulse
//   mem_out0..3_i             RAM load data
module tc_cheap_ram_requester #(
  parameter int unsigned BIT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned RAM_DEPTH      = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [15:0]          req_addr_i,
  input  logic [BIT_WIDTH-1:0] req_wdata0_i,
  input  logic [BIT_WIDTH-1:0] req_wdata1_i,
  input  logic [BIT_WIDTH-1:0] req_wdata2_i,
  input  logic [BIT_WIDTH-1:0] req_wdata3_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_err_o,
  output logic [BIT_WIDTH-1:0] resp_rdata0_o,
  output logic [BIT_WIDTH-1:0] resp_rdata1_o,
  output logic [BIT_WIDTH-1:0] resp_rdata2_o,
  output logic [BIT_WIDTH-1:0] resp_rdata3_o,
  output logic                 mem_load_o,
  output logic                 mem_save_o,
  output logic [15:0]          mem_address_o,
  output logic [BIT_WIDTH-1:0] mem_in0_o,
  output logic [BIT_WIDTH-1:0] mem_in1_o,
  output logic [BIT_WIDTH-1:0] mem_in2_o,
  output logic [BIT_WIDTH-1:0] mem_in3_o,
  input  logic                 mem_ready_i,
  input  logic [BIT_WIDTH-1:0] mem_out0_i,
  input  logic [BIT_WIDTH-1:0] mem_out1_i,
  input  logic [BIT_WIDTH-1:0] mem_out2_i,
  input  logic [BIT_WIDTH-1:0] mem_out3_i
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 || RAM_DEPTH == 0 || RAM_DEPTH > 65536)
  begin : g_bad_params
    $error("tc_cheap_ram_requester: illegal parameter value");
  end

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadIssue,
    StLoadWait,
    StSaveIssue,
    StResp
  } state_e;

  state_e                      state_q, state_d;
  logic   [7:0]                cnt_q, cnt_d;
  logic                        req_ready_q, req_ready_d;
  logic                        resp_valid_q, resp_valid_d;
  logic                        resp_err_q, resp_err_d;
  logic   [3:0][BIT_WIDTH-1:0] rdata_q, rdata_d;
  logic                        mem_load_q, mem_load_d;
  logic                        mem_save_q, mem_save_d;
  logic   [15:0]               mem_address_q, mem_address_d;
  logic   [3:0][BIT_WIDTH-1:0] mem_in_q, mem_in_d;
  logic                        range_err;

`ifdef TC_RAM_REQ_RANGE_CHECK_EN
  // 17-bit sum so a base near 0xFFFF cannot wrap back into range.
  logic [16:0] last_word;
  assign last_word = {1'b0, req_addr_i} + 17'd3;
  assign range_err = last_word > 17'(RAM_DEPTH - 1);
`else
  assign range_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_err_d    = resp_err_q;
    rdata_d       = rdata_q;
    mem_load_d    = 1'b0;
    mem_save_d    = 1'b0;
    mem_address_d = mem_address_q;
    mem_in_d      = '0;

    unique case (state_q)
      StIdle: begin
        // mem_ready_i is deliberately not looked at here: stale pulses are dropped.
        if (req_valid_i && req_ready_q) begin
          req_ready_d = 1'b0;
          if (range_err) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = '0;
          end else if (req_write_i) begin
            state_d       = StSaveIssue;
            mem_save_d    = 1'b1;
            mem_address_d = req_addr_i;
            mem_in_d      = {req_wdata3_i, req_wdata2_i, req_wdata1_i, req_wdata0_i};
          end else begin
            state_d       = StLoadIssue;
            mem_load_d    = 1'b1;
            mem_address_d = req_addr_i;
          end
        end
      end

      StLoadIssue: begin
        state_d = StLoadWait;
        cnt_d   = '0;
      end

      StLoadWait: begin
        // Ready is tested first so it wins over a timeout on the same edge.
        if (mem_ready_i) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          rdata_d      = {mem_out3_i, mem_out2_i, mem_out1_i, mem_out0_i};
        end else if (cnt_q == CntLast) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          rdata_d      = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StSaveIssue: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        rdata_d      = '0;
      end

      StResp: begin
        // Returning to idle takes one full cycle before the next accept.
        if (resp_ready_i) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      rdata_q       <= '0;
      mem_load_q    <= 1'b0;
      mem_save_q    <= 1'b0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      rdata_q       <= rdata_d;
      mem_load_q    <= mem_load_d;
      mem_save_q    <= mem_save_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_err_o    = resp_err_q;
  assign resp_rdata0_o = rdata_q[0];
  assign resp_rdata1_o = rdata_q[1];
  assign resp_rdata2_o = rdata_q[2];
  assign resp_rdata3_o = rdata_q[3];
  assign mem_load_o    = mem_load_q;
  assign mem_save_o    = mem_save_q;
  assign mem_address_o = mem_address_q;
  assign mem_in0_o     = mem_in_q[0];
  assign mem_in1_o     = mem_in_q[1];
  assign mem_in2_o     = mem_in_q[2];
  assign mem_in3_o     = mem_in_q[3];

endmodule

// File: tb/tb_tc_cheap_ram_requester.sv
// Bench for tc_cheap_ram_requester: directed requests against a 2-cycle-latency
// RAM model, with a queue of expected responses checked by a separate monitor.
module tb_tc_cheap_ram_requester;

`ifdef TC_RAM_REQ_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, resp_ready;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready_o, resp_valid_o, resp_err_o;
  logic [15:0] resp_rdata0_o, resp_rdata1_o, resp_rdata2_o, resp_rdata3_o;
  logic        mem_load_o, mem_save_o;
  logic [15:0] mem_address_o;
  logic [15:0] mem_in0_o, mem_in1_o, mem_in2_o, mem_in3_o;
  logic        ram_rdy = 1'b0;
  logic        stray;
  logic [3:0][15:0] ram_out = '0;

  tc_cheap_ram_requester #(
    .BIT_WIDTH(16),
    .TIMEOUT_CYCLES(8),
    .RAM_DEPTH(256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata0_i (req_wdata[15:0]),
    .req_wdata1_i (req_wdata[31:16]),
    .req_wdata2_i (req_wdata[47:32]),
    .req_wdata3_i (req_wdata[63:48]),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready),
    .resp_err_o   (resp_err_o),
    .resp_rdata0_o(resp_rdata0_o),
    .resp_rdata1_o(resp_rdata1_o),
    .resp_rdata2_o(resp_rdata2_o),
    .resp_rdata3_o(resp_rdata3_o),
    .mem_load_o   (mem_load_o),
    .mem_save_o   (mem_save_o),
    .mem_address_o(mem_address_o),
    .mem_in0_o    (mem_in0_o),
    .mem_in1_o    (mem_in1_o),
    .mem_in2_o    (mem_in2_o),
    .mem_in3_o    (mem_in3_o),
    .mem_ready_i  (ram_rdy | stray),
    .mem_out0_i   (ram_out[0]),
    .mem_out1_i   (ram_out[1]),
    .mem_out2_i   (ram_out[2]),
    .mem_out3_i   (ram_out[3])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: commits saves on the negedge, answers loads two cycles later.
  logic [15:0] ram [256];
  logic        ram_init = 1'b0;
  logic        ram_en;
  logic        pend = 1'b0;
  logic [15:0] ram_addr = '0;
  int          load_cnt = 0;
  int          save_cnt = 0;

  always @(negedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] = '0;
      ram_init = 1'b1;
    end
    if (mem_save_o) begin
      ram[8'(mem_address_o + 16'd0)] = mem_in0_o;
      ram[8'(mem_address_o + 16'd1)] = mem_in1_o;
      ram[8'(mem_address_o + 16'd2)] = mem_in2_o;
      ram[8'(mem_address_o + 16'd3)] = mem_in3_o;
    end
  end

  always @(negedge clk) begin
    if (mem_load_o) load_cnt <= load_cnt + 1;
    if (mem_save_o) save_cnt <= save_cnt + 1;
  end

  always @(posedge clk) begin
    ram_rdy <= 1'b0;
    if (pend) begin
      pend <= 1'b0;
      if (ram_en) begin
        ram_rdy <= 1'b1;
        for (int i = 0; i < 4; i++) ram_out[i] <= ram[8'(ram_addr + 16'(i))];
      end
    end
    if (mem_load_o) begin
      pend     <= 1'b1;
      ram_addr <= mem_address_o;
    end
  end

  typedef struct {
    logic        err;
    logic [63:0] d;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   last_accept = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic prev_v = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid_o && !prev_v) begin
        chk("resp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_err", 64'(resp_err_o), 64'(e.err));
          chk("resp_rdata", {resp_rdata3_o, resp_rdata2_o, resp_rdata1_o, resp_rdata0_o}, e.d);
          chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      prev_v = resp_valid_o && !rst;
    end
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [63:0] wd,
                       input logic push, input logic err, input logic [63:0] rd,
                       input int lat);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < 100), 64'd1);
    @(posedge clk);
    #1;
    last_accept = cyc;
    req_valid = 1'b0;
    if (push) begin
      e.err = err;
      e.d   = rd;
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !req_ready_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(n < 100), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] D1234 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] DABCD = 64'h000D_000C_000B_000A;

  initial begin
    int l0, s0, n, hs, vcnt;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b1;
    stray = 1'b0;
    ram_en = 1'b1;
    fork
      monitor();
    join_none

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_err", 64'(resp_err_o), 64'd0);
    chk("rst_mem_cmd", {mem_load_o, mem_save_o}, 64'd0);
    chk("rst_mem_address", 64'(mem_address_o), 64'd0);
    chk("rst_mem_in", {mem_in3_o, mem_in2_o, mem_in1_o, mem_in0_o}, 64'd0);
    chk("rst_rdata", {resp_rdata3_o, resp_rdata2_o, resp_rdata1_o, resp_rdata0_o}, 64'd0);
    rst = 1'b0;

    // Write 0x0010 <- 1,2,3,4.
    s0 = save_cnt;
    issue(1'b1, 16'h0010, D1234, 1'b1, 1'b0, 64'd0, 1);
    @(negedge clk);
    chk("wr_mem_save", 64'(mem_save_o), 64'd1);
    chk("wr_mem_address", 64'(mem_address_o), 64'h0010);
    chk("wr_mem_in", {mem_in3_o, mem_in2_o, mem_in1_o, mem_in0_o}, D1234);
    wait_done();
    chk("wr_save_pulses", 64'(save_cnt - s0), 64'd1);
    chk("idle_mem_in", {mem_in3_o, mem_in2_o, mem_in1_o, mem_in0_o}, 64'd0);
    chk("idle_mem_address_held", 64'(mem_address_o), 64'h0010);

    // Read 0x0010 back.
    l0 = load_cnt;
    issue(1'b0, 16'h0010, 64'd0, 1'b1, 1'b0, D1234, 3);
    @(negedge clk);
    chk("rd_mem_load", 64'(mem_load_o), 64'd1);
    wait_done();
    chk("rd_load_pulses", 64'(load_cnt - l0), 64'd1);

    // Timeout: RAM never answers.
    ram_en = 1'b0;
    issue(1'b0, 16'h0020, 64'd0, 1'b1, 1'b1, 64'd0, 9);
    wait_done();

    // mem_ready on the same edge as the timeout: ready wins, data = last RAM output.
    issue(1'b0, 16'h0050, 64'd0, 1'b1, 1'b0, D1234, 9);
    repeat (9) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    wait_done();
    ram_en = 1'b1;

    // Held response; a pending request waits for the handshake plus one idle cycle.
    resp_ready = 1'b0;
    issue(1'b0, 16'h0010, 64'd0, 1'b1, 1'b0, D1234, 3);
    n = 0;
    while (!resp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", 64'(resp_valid_o), 64'd1);
    hs = 0;
    fork
      issue(1'b1, 16'h0040, 64'h000C_000B_000A_0009, 1'b1, 1'b0, 64'd0, 1);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("hold_resp_valid", 64'(resp_valid_o), 64'd1);
          chk("hold_rdata", {resp_rdata3_o, resp_rdata2_o, resp_rdata1_o, resp_rdata0_o}, D1234);
          chk("hold_req_ready", 64'(req_ready_o), 64'd0);
        end
        resp_ready = 1'b1;
        hs = cyc + 1;
      end
    join
    chk("hold_accept_gap", 64'(last_accept), 64'(hs + 1));
    wait_done();

    // Address 0xFFFE passes through unchanged; the RAM wraps the words.
    s0 = save_cnt;
    issue(1'b1, 16'hFFFE, DABCD, 1'b1, RC, 64'd0, 1);
    @(negedge clk);
`ifndef TC_RAM_REQ_RANGE_CHECK_EN
    chk("wrap_mem_address", 64'(mem_address_o), 64'hFFFE);
`endif
    chk("wrap_mem_save", 64'(mem_save_o), 64'(!RC));
    wait_done();
    chk("wrap_save_pulses", 64'(save_cnt - s0), 64'(!RC));
    issue(1'b0, 16'hFFFE, 64'd0, 1'b1, RC, RC ? 64'd0 : DABCD, RC ? 1 : 3);
    wait_done();

`ifdef TC_RAM_REQ_RANGE_CHECK_EN
    l0 = load_cnt;
    issue(1'b0, 16'h00FD, 64'd0, 1'b1, 1'b1, 64'd0, 1);
    wait_done();
    chk("range_fd_no_load", 64'(load_cnt - l0), 64'd0);
    l0 = load_cnt;
    issue(1'b0, 16'h00FC, 64'd0, 1'b1, 1'b0, 64'd0, 3);
    wait_done();
    chk("range_fc_load", 64'(load_cnt - l0), 64'd1);
`endif

    // Reset during LOAD_WAIT drops the transaction.
    ram_en = 1'b0;
    issue(1'b0, 16'h0010, 64'd0, 1'b0, 1'b0, 64'd0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("midrst_req_ready", 64'(req_ready_o), 64'd1);
    chk("midrst_mem_load", 64'(mem_load_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid_o) vcnt++;
    end
    chk("stray_no_resp", 64'(vcnt), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
